// File: rtl/reg_file_wb_scoreboard.sv
// reg_file_wb_scoreboard
//   Write-back scoreboard for a register file. Decodes the destination of an
//   issuing instruction and tracks its pending write through a fixed-latency
//   pipeline. Issue is stalled on RAW/WAW hazards against pending writes.
//   Drives the register-file write port and counts completed writes.
//
// Ports
//   w_clock            : clock, rising edge
//   w_reset_n          : asynchronous active-low reset
//   w_issue_valid      : instruction presented for issue
//   w_*_op             : decoded instruction class bits
//   w_rd, w_rt         : candidate destination registers
//   w_rs_query,
//   w_rt_query         : source registers of the issuing instruction
//   w_flush            : kill all in-flight writes not yet at the output
//   w_stall_out        : issue blocked by a hazard this cycle
//   w_wen_out          : register-file write enable (registered)
//   w_waddr_out        : register-file write address (registered)
//   w_busy_out         : per-register pending-write bitmap
//   w_commit_cnt_out   : wrapping count of writes performed
module reg_file_wb_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LAT      = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                     w_clock,
  input  logic                     w_reset_n,
  input  logic                     w_issue_valid,
  input  logic                     w_alu_op,
  input  logic                     w_imm_op,
  input  logic                     w_jump_op,
  input  logic                     w_reg_jump_op,
  input  logic                     w_link_op,
  input  logic                     w_mem_op,
  input  logic                     w_write_op,
  input  logic [ADDR_W-1:0]        w_rd,
  input  logic [ADDR_W-1:0]        w_rt,
  input  logic [ADDR_W-1:0]        w_rs_query,
  input  logic [ADDR_W-1:0]        w_rt_query,
  input  logic                     w_flush,
  output logic                     w_stall_out,
  output logic                     w_wen_out,
  output logic [ADDR_W-1:0]        w_waddr_out,
  output logic [(1<<ADDR_W)-1:0]   w_busy_out,
  output logic [15:0]              w_commit_cnt_out
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [ADDR_W-1:0] dest;
  logic              write_needed;
  logic              accept;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [NREGS-1:0]  busy;

  logic              stage_valid [LAT];
  logic [ADDR_W-1:0] stage_addr  [LAT];
  logic [15:0]       commit_cnt;

  // Destination select, highest priority first.
  always_comb begin
    dest = '0;
    if (w_mem_op)                        dest = w_rt;
    else if (w_alu_op && w_imm_op)       dest = w_rt;
    else if (w_jump_op && w_reg_jump_op) dest = w_rd;
    else if (w_jump_op && w_link_op)     dest = LINK_ADDR;
    else if (w_alu_op)                   dest = w_rd;
  end

  always_comb begin
    write_needed = (w_alu_op
                    | (w_mem_op & ~w_write_op)
                    | (w_jump_op & w_reg_jump_op)
                    | (w_jump_op & w_link_op))
                   & (dest != '0);
  end

  // Destination busy only matters when the instruction actually writes;
  // busy[0] is forced low so queries to r0 never stall.
  always_comb begin
    w_stall_out = w_issue_valid & ~w_flush
                  & (busy[w_rs_query] | busy[w_rt_query]
                     | (write_needed & busy[dest]));
    accept      = w_issue_valid & ~w_stall_out & ~w_flush;
    load_valid  = accept & write_needed;
    load_addr   = load_valid ? dest : '0;
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        stage_valid[i] <= 1'b0;
        stage_addr[i]  <= '0;
      end
    end else if (w_flush) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        stage_valid[i] <= 1'b0;
        stage_addr[i]  <= '0;
      end
    end else begin
      stage_valid[0] <= load_valid;
      stage_addr[0]  <= load_addr;
      for (int unsigned i = 1; i < LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_addr[i]  <= stage_addr[i-1];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      if (stage_valid[i]) busy[stage_addr[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n)     commit_cnt <= '0;
    else if (w_wen_out) commit_cnt <= commit_cnt + 16'd1;
  end

  assign w_wen_out        = stage_valid[LAT-1];
  assign w_waddr_out      = stage_addr[LAT-1];
  assign w_busy_out       = busy;
  assign w_commit_cnt_out = commit_cnt;

endmodule

// File: tb/tb_reg_file_wb_scoreboard.sv
// Testbench for reg_file_wb_scoreboard. Expected writes are queued with the
// cycle they must appear on the write port; every clock tick compares the
// write port and commit counter against the queue head.
module tb_reg_file_wb_scoreboard;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned LAT      = 3;
  localparam int unsigned LINK_REG = 31;
  localparam int unsigned NREGS    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic              alu_op, imm_op, jump_op, reg_jump_op, link_op, mem_op, write_op;
  logic [ADDR_W-1:0] rd, rt, rs_query, rt_query;
  logic              flush;
  logic              stall;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [NREGS-1:0]  busy;
  logic [15:0]       commit_cnt;

  always #5 clk = ~clk;

  reg_file_wb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .LAT      (LAT),
    .LINK_REG (LINK_REG)
  ) dut (
    .w_clock          (clk),
    .w_reset_n        (rst_n),
    .w_issue_valid    (issue_valid),
    .w_alu_op         (alu_op),
    .w_imm_op         (imm_op),
    .w_jump_op        (jump_op),
    .w_reg_jump_op    (reg_jump_op),
    .w_link_op        (link_op),
    .w_mem_op         (mem_op),
    .w_write_op       (write_op),
    .w_rd             (rd),
    .w_rt             (rt),
    .w_rs_query       (rs_query),
    .w_rt_query       (rt_query),
    .w_flush          (flush),
    .w_stall_out      (stall),
    .w_wen_out        (wen),
    .w_waddr_out      (waddr),
    .w_busy_out       (busy),
    .w_commit_cnt_out (commit_cnt)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } exp_t;

  exp_t        sb[$];
  int          edge_cnt = 0;
  int          checks   = 0;
  int          fails    = 0;
  logic [15:0] exp_cnt  = '0;
  bit          prev_exp = 1'b0;

  // Expect a write of addr on the port after edge (next edge + LAT - 1).
  task automatic push_exp(input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.addr = addr;
    e.due  = edge_cnt + int'(LAT);
    sb.push_back(e);
  endtask

  task automatic tick();
    bit exp_wen;
    @(posedge clk);
    edge_cnt++;
    if (prev_exp) exp_cnt++;
    #1;
    exp_wen = (sb.size() > 0) && (sb[0].due == edge_cnt);
    checks++;
    if (wen !== exp_wen) begin
      fails++;
      $display("FAIL sb_wen edge %0d: got %b expected %b", edge_cnt, wen, exp_wen);
    end
    if (exp_wen) begin
      checks++;
      if (waddr !== sb[0].addr) begin
        fails++;
        $display("FAIL sb_waddr edge %0d: got %0d expected %0d", edge_cnt, waddr, sb[0].addr);
      end
      void'(sb.pop_front());
    end
    prev_exp = exp_wen;
    checks++;
    if (commit_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL sb_commit_cnt edge %0d: got %0d expected %0d", edge_cnt, commit_cnt, exp_cnt);
    end
  endtask

  task automatic present(input logic v, input logic alu, input logic imm, input logic jmp,
                         input logic rjmp, input logic lnk, input logic mem, input logic wr,
                         input logic [ADDR_W-1:0] d_rd, input logic [ADDR_W-1:0] d_rt,
                         input logic [ADDR_W-1:0] q_rs, input logic [ADDR_W-1:0] q_rt);
    issue_valid = v;   alu_op  = alu; imm_op   = imm; jump_op  = jmp;
    reg_jump_op = rjmp; link_op = lnk; mem_op   = mem; write_op = wr;
    rd = d_rd; rt = d_rt; rs_query = q_rs; rt_query = q_rt;
    #1;
  endtask

  task automatic idle();
    present(0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    checks++; if (wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b expected 0", wen); end
    checks++; if (waddr !== '0) begin fails++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
    checks++; if (busy !== '0) begin fails++; $display("FAIL reset_busy: got %h expected 0", busy); end
    checks++; if (commit_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", commit_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Runs straight after reset release, so the first edge must accept.
  task automatic test_rtype();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd1, 5'd2);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL rtype_stall: got %b expected 0", stall); end
    push_exp(5'd7);
    tick();
    idle();
    repeat (LAT) begin
      checks++; if (busy[7] !== 1'b1) begin fails++; $display("FAIL rtype_busy7_set: got %b expected 1", busy[7]); end
      tick();
    end
    checks++; if (busy[7] !== 1'b0) begin fails++; $display("FAIL rtype_busy7_clear: got %b expected 0", busy[7]); end
    checks++; if (commit_cnt !== 16'd1) begin fails++; $display("FAIL rtype_cnt: got %0d expected 1", commit_cnt); end
  endtask

  task automatic test_load_use();
    present(1, 0, 0, 0, 0, 0, 1, 0, 5'd3, 5'd9, 5'd0, 5'd0);
    push_exp(5'd9);
    tick();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd12, 5'd0, 5'd9, 5'd0);
    repeat (LAT) begin
      checks++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b expected 1", stall); end
      tick();
    end
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_release: got %b expected 0", stall); end
    push_exp(5'd12);
    tick();
    idle();
    repeat (LAT + 1) tick();
    checks++; if (busy !== '0) begin fails++; $display("FAIL load_use_busy_end: got %h expected 0", busy); end
  endtask

  task automatic test_r0_store();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_stall: got %b expected 0", stall); end
    tick();
    checks++; if (busy !== '0) begin fails++; $display("FAIL r0_busy: got %h expected 0", busy); end
    present(1, 0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd9, 5'd1, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL store_stall: got %b expected 0", stall); end
    tick();
    idle();
    checks++; if (busy !== '0) begin fails++; $display("FAIL store_busy: got %h expected 0", busy); end
    repeat (LAT + 1) tick();
  endtask

  task automatic test_link();
    logic [NREGS-1:0] e;
    present(1, 0, 0, 1, 0, 1, 0, 0, 5'd5, 5'd6, 5'd0, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL link_stall: got %b expected 0", stall); end
    push_exp(ADDR_W'(LINK_REG));
    tick();
    present(1, 0, 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL jalr_r0_stall: got %b expected 0", stall); end
    tick();
    idle();
    e = '0;
    e[LINK_REG] = 1'b1;
    checks++; if (busy !== e) begin fails++; $display("FAIL link_busy: got %h expected %h", busy, e); end
    repeat (LAT) tick();
    checks++; if (busy !== '0) begin fails++; $display("FAIL link_busy_end: got %h expected 0", busy); end
  endtask

  task automatic test_dest_priority();
    logic [NREGS-1:0] e;
    present(1, 1, 1, 0, 0, 0, 0, 0, 5'd3, 5'd13, 5'd0, 5'd0);
    push_exp(5'd13);
    tick();
    present(1, 1, 0, 0, 0, 0, 1, 0, 5'd4, 5'd14, 5'd0, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL prio_mem_stall: got %b expected 0", stall); end
    push_exp(5'd14);
    tick();
    present(1, 0, 0, 1, 1, 1, 0, 0, 5'd15, 5'd2, 5'd0, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL prio_jalr_stall: got %b expected 0", stall); end
    push_exp(5'd15);
    tick();
    e = '0;
    e[13] = 1'b1; e[14] = 1'b1; e[15] = 1'b1;
    checks++; if (busy !== e) begin fails++; $display("FAIL prio_busy: got %h expected %h", busy, e); end
    present(1, 0, 0, 0, 0, 0, 0, 0, 5'd16, 5'd16, 5'd0, 5'd0);
    tick();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd17, 5'd18, 5'd0, 5'd0);
    push_exp(5'd17);
    tick();
    idle();
    repeat (LAT + 1) tick();
    checks++; if (busy !== '0) begin fails++; $display("FAIL prio_busy_end: got %h expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 21; i <= 23; i++) begin
      present(1, 1, 0, 0, 0, 0, 0, 0, ADDR_W'(i), 5'd0, 5'd0, 5'd0);
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall_%0d: got %b expected 0", i, stall); end
      push_exp(ADDR_W'(i));
      tick();
    end
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd21, 5'd0, 5'd0, 5'd0);
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_stall: got %b expected 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL waw_release: got %b expected 0", stall); end
    push_exp(5'd21);
    tick();
    idle();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_flush();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0, 5'd0, 5'd0);
    push_exp(5'd3);
    tick();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0, 5'd0, 5'd0);
    tick();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd0, 5'd0);
    tick();
    // Write of r3 is on the port now; flush with a hazarding issue alongside.
    flush = 1'b1;
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd6, 5'd0, 5'd4, 5'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b expected 0", stall); end
    tick();
    flush = 1'b0;
    idle();
    checks++; if (busy !== '0) begin fails++; $display("FAIL flush_busy: got %h expected 0", busy); end
    repeat (LAT + 1) tick();
    checks++; if (busy !== '0) begin fails++; $display("FAIL flush_busy_end: got %h expected 0", busy); end
  endtask

  task automatic test_reset_midflight();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd10, 5'd0, 5'd0, 5'd0);
    tick();
    present(1, 1, 0, 0, 0, 0, 0, 0, 5'd11, 5'd0, 5'd0, 5'd0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (wen !== 1'b0) begin fails++; $display("FAIL async_reset_wen: got %b expected 0", wen); end
    checks++; if (waddr !== '0) begin fails++; $display("FAIL async_reset_waddr: got %0d expected 0", waddr); end
    checks++; if (busy !== '0) begin fails++; $display("FAIL async_reset_busy: got %h expected 0", busy); end
    checks++; if (commit_cnt !== '0) begin fails++; $display("FAIL async_reset_cnt: got %0d expected 0", commit_cnt); end
    sb.delete();
    exp_cnt  = '0;
    prev_exp = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (LAT + 2) tick();
    checks++; if (commit_cnt !== '0) begin fails++; $display("FAIL post_reset_cnt: got %0d expected 0", commit_cnt); end
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_r0_store();
    test_link();
    test_dest_priority();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
